// File: rtl/text_console_ctrl.sv
// Character-RAM write sequencer: decodes a byte stream into cursor moves, single writes and clear sweeps.
// One write cycle after each accepted byte; char_ready is low for the whole of a line or screen clear sweep.
module text_console_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              px_clk,
    input  logic              rstn,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COLS_M1_A = ADDR_W'(COLS-1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [6:0]        LAST_COL  = 7'(COLS-1);
    localparam logic [5:0]        LAST_ROW  = 6'(ROWS-1);
    localparam logic [7:0]        SPACE     = 8'h20;

    typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_LINE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_sweep;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_row_base;
    logic [6:0]        r_col;
    logic [5:0]        r_row;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;

    logic              w_accept;
    logic              w_last_row;
    logic [5:0]        w_next_row;
    logic [ADDR_W-1:0] w_next_base;
    logic [ADDR_W-1:0] w_line_last;

    assign w_accept    = char_valid && (r_state == IDLE);
    assign w_last_row  = (r_row == LAST_ROW);
    assign w_next_row  = w_last_row ? 6'd0 : r_row + 6'd1;
    // Row base advances by COLS instead of multiplying row*COLS.
    assign w_next_base = w_last_row ? '0 : r_row_base + COLS_A;
    assign w_line_last = r_row_base + COLS_M1_A;

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= CLR_SCREEN;
            r_sweep    <= '0;
            r_cur_addr <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (char_data >= 8'h20) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_cur_addr;
                            r_wdata <= char_data;
                            if (r_col == LAST_COL) begin
                                // Character write goes out first; the line sweep follows next cycle.
                                r_col      <= '0;
                                r_row      <= w_next_row;
                                r_row_base <= w_next_base;
                                r_cur_addr <= w_next_base;
                                r_sweep    <= w_next_base;
                                r_state    <= CLR_LINE;
                            end else begin
                                r_col      <= r_col + 7'd1;
                                r_cur_addr <= r_cur_addr + ONE_A;
                            end
                        end else begin
                            case (char_data)
                                8'h0D: begin
                                    r_col      <= '0;
                                    r_cur_addr <= r_row_base;
                                end
                                8'h0A: begin
                                    // First sweep write is issued on the accept edge itself.
                                    r_col      <= '0;
                                    r_row      <= w_next_row;
                                    r_row_base <= w_next_base;
                                    r_cur_addr <= w_next_base;
                                    r_we       <= 1'b1;
                                    r_waddr    <= w_next_base;
                                    r_wdata    <= SPACE;
                                    r_sweep    <= w_next_base + ONE_A;
                                    r_state    <= CLR_LINE;
                                end
                                8'h08: begin
                                    if (r_col != 7'd0) begin
                                        r_col      <= r_col - 7'd1;
                                        r_cur_addr <= r_cur_addr - ONE_A;
                                        r_we       <= 1'b1;
                                        r_waddr    <= r_cur_addr - ONE_A;
                                        r_wdata    <= SPACE;
                                    end
                                end
                                8'h0C: begin
                                    r_col      <= '0;
                                    r_row      <= '0;
                                    r_row_base <= '0;
                                    r_cur_addr <= '0;
                                    r_we       <= 1'b1;
                                    r_waddr    <= '0;
                                    r_wdata    <= SPACE;
                                    r_sweep    <= ONE_A;
                                    r_state    <= CLR_SCREEN;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_SCREEN: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_sweep;
                    r_wdata <= SPACE;
                    if (r_sweep == LAST_ADDR) begin
                        r_sweep <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_sweep <= r_sweep + ONE_A;
                    end
                end
                CLR_LINE: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_sweep;
                    r_wdata <= SPACE;
                    if (r_sweep == w_line_last) begin
                        r_sweep <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_sweep <= r_sweep + ONE_A;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign char_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign cursor_col = r_col;
    assign cursor_row = r_row;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: boot clear, printing, control codes, wrap and reset mid-sweep.
module tb_text_console_ctrl;

    logic        px_clk = 1'b0;
    logic        rstn;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        we;
    logic [12:0] waddr;
    logic [7:0]  wdata;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_console_ctrl #(.COLS(80), .ROWS(60), .ADDR_W(13)) dut (
        .px_clk     (px_clk),
        .rstn       (rstn),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 px_clk = ~px_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    // Returns 1ns after the accepting edge, i.e. in the cycle carrying the resulting write.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge px_clk);
        while (!char_ready && n < 6000) begin
            @(negedge px_clk);
            n++;
        end
        chk("send_ready", 32'(char_ready), 32'd1);
        char_valid = 1'b1;
        char_data  = b;
        @(posedge px_clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic cur(input string tag, input int c, input int r);
        chk(tag, 32'(cursor_row) * 256 + 32'(cursor_col), 32'(r * 256 + c));
    endtask

    task automatic wr(input string tag, input int addr, input logic [7:0] d);
        logic [12:0] a;
        a = 13'(addr);
        chk(tag, 32'({we, waddr, wdata}), 32'({1'b1, a, d}));
    endtask

    // Checks count consecutive space writes starting in the current cycle.
    task automatic sweep(input string tag, input int base, input int count);
        logic [12:0] a;
        logic        last;
        for (int i = 0; i < count; i++) begin
            if (i > 0) tick();
            a    = 13'(base + i);
            last = (i == count - 1);
            chk(tag, 32'({we, waddr, wdata, char_ready}), 32'({1'b1, a, 8'h20, last}));
        end
    endtask

    initial begin
        rstn       = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (3) tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        cur("rst_cursor", 0, 0);

        @(negedge px_clk);
        rstn = 1'b1;
        tick();
        sweep("boot_clear", 0, 4800);
        tick();
        chk("boot_done_we", 32'(we), 32'd0);
        chk("boot_done_busy", 32'(busy), 32'd0);
        cur("boot_cursor", 0, 0);

        send(8'h41); wr("wr_A", 0, 8'h41);
        send(8'h42); wr("wr_B", 1, 8'h42);
        cur("ab_cursor", 2, 0);

        send(8'h0D); chk("cr_we", 32'(we), 32'd0); cur("cr_cursor", 0, 0);
        send(8'h01); chk("ctl_we", 32'(we), 32'd0); cur("ctl_cursor", 0, 0);

        for (int r = 1; r <= 2; r++) begin
            send(8'h0A);
            sweep("lf_clear", 80 * r, 80);
            tick();
        end
        cur("row2_cursor", 0, 2);

        send(8'h08); chk("bs0_we", 32'(we), 32'd0); cur("bs0_cursor", 0, 2);
        send(8'h61); wr("wr_a", 160, 8'h61);
        send(8'h62); wr("wr_b", 161, 8'h62);
        send(8'h63); wr("wr_c", 162, 8'h63);
        cur("abc_cursor", 3, 2);
        send(8'h08); wr("bs3_wr", 162, 8'h20); cur("bs3_cursor", 2, 2);
        tick();
        chk("bs3_single", 32'(we), 32'd0);

        send(8'h0D);
        send(8'h0A); cur("lf3_cursor", 0, 3); sweep("lf3_clear", 240, 80); tick();
        send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F);
        wr("wr_O", 244, 8'h4F);
        cur("hello_cursor", 5, 3);
        send(8'h0A); cur("lf4_cursor", 0, 4);
        sweep("lf4_clear", 320, 80);
        tick();
        chk("lf4_done_we", 32'(we), 32'd0);

        send(8'h0C); cur("ff_cursor", 0, 0);
        sweep("ff_clear", 0, 4800);
        tick();
        for (int r = 1; r <= 59; r++) begin
            send(8'h0A);
            sweep("lf_walk", 80 * r, 80);
            tick();
        end
        cur("row59_cursor", 0, 59);
        for (int i = 0; i < 79; i++) send(8'h78);
        wr("wr_4798", 4798, 8'h78);
        cur("col79_cursor", 79, 59);
        send(8'h5A);
        wr("wrap_wr", 4799, 8'h5A);
        chk("wrap_ready", 32'(char_ready), 32'd0);
        cur("wrap_cursor", 0, 0);
        tick();
        sweep("wrap_clear", 0, 80);
        tick();
        chk("wrap_done_we", 32'(we), 32'd0);

        send(8'h51); wr("wr_Q", 0, 8'h51); cur("q_cursor", 1, 0);
        send(8'h0C); wr("ff2_first", 0, 8'h20);
        repeat (1000) tick();
        wr("ff2_at1000", 1000, 8'h20);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_ready", 32'(char_ready), 32'd0);
        tick();
        tick();
        @(negedge px_clk);
        rstn = 1'b1;
        tick();
        cur("reboot_cursor", 0, 0);
        sweep("reboot_clear", 0, 4800);
        tick();
        chk("reboot_done_we", 32'(we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
